// File: rtl/start_store_seq_if.sv
// ============================================================================
// Module   : start_store_seq_if
// Purpose  : Control, handshake and start_store command bundle for start_store_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface start_store_seq_if;
  logic        fwd_start;
  logic        bwd_start;
  logic [31:0] cfg_rows;
  logic        fwd_valid;
  logic        fwd_ready;
  logic        bwd_ready;
  logic        store;
  logic [31:0] store_address;
  logic [31:0] store_row;
  logic        load;
  logic [31:0] load_address;
  logic [31:0] load_row;
  logic [31:0] load_data_set;
  logic        reset_counter;
  logic        bwd_valid;
  logic [31:0] bwd_layer;
  logic [31:0] bwd_row;
  logic        bwd_set;
  logic        busy;
  logic        done;
  logic        err;

  // Sequencer side.
  modport slave (
    input  fwd_start, bwd_start, cfg_rows, fwd_valid, bwd_ready,
    output fwd_ready, store, store_address, store_row,
           load, load_address, load_row, load_data_set, reset_counter,
           bwd_valid, bwd_layer, bwd_row, bwd_set, busy, done, err
  );

  // Layer engine / consumer side.
  modport master (
    output fwd_start, bwd_start, cfg_rows, fwd_valid, bwd_ready,
    input  fwd_ready, store, store_address, store_row,
           load, load_address, load_row, load_data_set, reset_counter,
           bwd_valid, bwd_layer, bwd_row, bwd_set, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/start_store_seq.sv
// ============================================================================
// Module   : start_store_seq
// Purpose  : Forward store / reverse-order backward load sequencer for start_store.
//            START_STORE_SEQ_ACT_ONLY_EN: backward pass loads data set 1 only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module start_store_seq #(
  parameter int unsigned MAX_LAYER_SIZE = 5,
  parameter int unsigned LAYER_COUNT    = 3
) (
  input  logic             clk,
  input  logic             reset,
  start_store_seq_if.slave bus
);

  localparam logic [31:0] MAX_ROWS   = 32'(MAX_LAYER_SIZE);
  localparam logic [31:0] LAST_LAYER = 32'(LAYER_COUNT - 1);
`ifdef START_STORE_SEQ_ACT_ONLY_EN
  localparam logic        SET_FIRST  = 1'b1;
`else
  localparam logic        SET_FIRST  = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_FWD  = 3'd2,
    S_BWD  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t      state_q;
  logic        dir_bwd_q;
  logic [31:0] rows_q;
  logic [31:0] flayer_q, frow_q;
  logic [31:0] blayer_q, brow_q;
  logic        bset_q;
  logic        fwd_ready_q, busy_q, done_q, err_q, rstc_q;
  logic        bvalid_q, btag_set_q;
  logic [31:0] btag_layer_q, btag_row_q;

  logic store_d, load_d, start_d, cfg_bad_d;

  assign store_d   = bus.fwd_valid & fwd_ready_q;
  assign load_d    = (state_q == S_BWD) & bus.bwd_ready;
  assign start_d   = bus.fwd_start | bus.bwd_start;
  assign cfg_bad_d = (bus.cfg_rows == 32'd0) || (bus.cfg_rows > MAX_ROWS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dir_bwd_q    <= 1'b0;
      rows_q       <= '0;
      flayer_q     <= '0;
      frow_q       <= '0;
      blayer_q     <= '0;
      brow_q       <= '0;
      bset_q       <= 1'b0;
      fwd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rstc_q       <= 1'b0;
      bvalid_q     <= 1'b0;
      btag_set_q   <= 1'b0;
      btag_layer_q <= '0;
      btag_row_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rstc_q   <= 1'b0;
      // Read data returns one cycle after the load, independent of bwd_ready.
      bvalid_q <= load_d;
      if (load_d) begin
        btag_layer_q <= blayer_q;
        btag_row_q   <= brow_q;
        btag_set_q   <= bset_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            if (cfg_bad_d) begin
              err_q <= 1'b1;
            end else begin
              rows_q    <= bus.cfg_rows;
              busy_q    <= 1'b1;
              dir_bwd_q <= ~bus.fwd_start;
              rstc_q    <= 1'b1;
              state_q   <= S_CLR;
            end
          end
        end
        S_CLR: begin
          if (dir_bwd_q) begin
            blayer_q <= LAST_LAYER;
            brow_q   <= '0;
            bset_q   <= SET_FIRST;
            state_q  <= S_BWD;
          end else begin
            flayer_q    <= '0;
            frow_q      <= '0;
            fwd_ready_q <= 1'b1;
            state_q     <= S_FWD;
          end
        end
        S_FWD: begin
          if (store_d) begin
            if (frow_q == rows_q - 32'd1) begin
              if (flayer_q == LAST_LAYER) begin
                fwd_ready_q <= 1'b0;
                state_q     <= S_FIN;
              end else begin
                frow_q   <= '0;
                flayer_q <= flayer_q + 32'd1;
              end
            end else begin
              frow_q <= frow_q + 32'd1;
            end
          end
        end
        S_BWD: begin
          // Order: layer descending, set ascending, row ascending.
          if (load_d) begin
            if (brow_q == rows_q - 32'd1) begin
              if (bset_q) begin
                if (blayer_q == 32'd0) begin
                  state_q <= S_FIN;
                end else begin
                  brow_q   <= '0;
                  bset_q   <= SET_FIRST;
                  blayer_q <= blayer_q - 32'd1;
                end
              end else begin
                brow_q <= '0;
                bset_q <= 1'b1;
              end
            end else begin
              brow_q <= brow_q + 32'd1;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.fwd_ready     = fwd_ready_q;
  assign bus.store         = store_d;
  assign bus.store_address = flayer_q;
  assign bus.store_row     = frow_q;
  assign bus.load          = load_d;
  assign bus.load_address  = blayer_q;
  assign bus.load_row      = brow_q;
  assign bus.load_data_set = {31'd0, bset_q};
  assign bus.reset_counter = rstc_q;
  assign bus.bwd_valid     = bvalid_q;
  assign bus.bwd_layer     = btag_layer_q;
  assign bus.bwd_row       = btag_row_q;
  assign bus.bwd_set       = btag_set_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_start_store_seq.sv
// ============================================================================
// Module   : tb_start_store_seq
// Purpose  : Scoreboard bench for start_store_seq against a pass-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_start_store_seq;

  localparam int MAXR = 5;
  localparam int LC   = 3;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic        s;
  } cmd_t;

  logic clk;
  logic reset;
  start_store_seq_if bus ();

  start_store_seq #(.MAX_LAYER_SIZE(MAXR), .LAYER_COUNT(LC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   vectors    = 0;
  int   miscompares = 0;
  int   n_store    = 0;
  int   n_load     = 0;
  int   vmode      = 0;
  int   rmode      = 0;
  bit   man        = 1'b0;
  bit   man_ready  = 1'b1;
  cmd_t exp_store[$];
  cmd_t exp_load[$];
  int   exp_ctrl[$];     // 1 = reset_counter, 2 = done, 3 = err
  bit   prev_pend  = 1'b0;
  cmd_t prev_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a whole pass expressed as its ordered command list.
  task automatic model_pass(input bit f, input bit b, input int rows,
                            input int limit, input bit with_done);
    int   cnt;
    int   s_lo;
    cmd_t c;
    cnt = 0;
    if (!(f || b)) return;
    if (rows == 0 || rows > MAXR) begin
      exp_ctrl.push_back(3);
      return;
    end
    exp_ctrl.push_back(1);
    if (f) begin
      for (int l = 0; l < LC; l++)
        for (int r = 0; r < rows; r++) begin
          c = '{l: 32'(l), r: 32'(r), s: 1'b0};
          if (cnt < limit) exp_store.push_back(c);
          cnt++;
        end
    end else begin
`ifdef START_STORE_SEQ_ACT_ONLY_EN
      s_lo = 1;
`else
      s_lo = 0;
`endif
      for (int l = LC - 1; l >= 0; l--)
        for (int s = s_lo; s <= 1; s++)
          for (int r = 0; r < rows; r++) begin
            c = '{l: 32'(l), r: 32'(r), s: 1'(s)};
            if (cnt < limit) exp_load.push_back(c);
            cnt++;
          end
    end
    if (with_done) exp_ctrl.push_back(2);
  endtask

  task automatic start_pass(input bit f, input bit b, input int rows,
                            input int limit, input bit with_done);
    model_pass(f, b, rows, limit, with_done);
    @(posedge clk); #1;
    bus.fwd_start = f;
    bus.bwd_start = b;
    bus.cfg_rows  = 32'(rows);
    @(posedge clk); #1;
    bus.fwd_start = 1'b0;
    bus.bwd_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (i < 500 && (exp_ctrl.size() != 0 || exp_store.size() != 0 ||
                       exp_load.size() != 0 || prev_pend)) begin
      @(negedge clk); #1;
      i++;
    end
    chk({name, "_drain_left"}, exp_ctrl.size() + exp_store.size() + exp_load.size(), 0);
    chk({name, "_busy_end"}, bus.busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {bus.busy, bus.done, bus.err, bus.fwd_ready, bus.store, bus.load,
                         bus.reset_counter, bus.bwd_valid, bus.bwd_set}, 0);
    chk({name, "_addr"}, {32'd0, bus.store_address | bus.store_row | bus.load_address |
                          bus.load_row | bus.load_data_set | bus.bwd_layer | bus.bwd_row}, 0);
  endtask

  // Producer/consumer handshake driver.
  initial begin
    bus.fwd_valid = 1'b1;
    bus.bwd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.fwd_valid = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bwd_ready = man ? man_ready : ((rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    cmd_t e;
    bit   cur_pend;
    int   code;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_pend = 1'b0;
      end else begin
        chk("bwd_valid", bus.bwd_valid, prev_pend);
        if (prev_pend && bus.bwd_valid) begin
          chk("bwd_layer", bus.bwd_layer, prev_cmd.l);
          chk("bwd_row", bus.bwd_row, prev_cmd.r);
          chk("bwd_set", bus.bwd_set, prev_cmd.s);
        end
        cur_pend = 1'b0;
        if (bus.load) begin
          n_load++;
          chk("load_needs_ready", bus.bwd_ready, 1'b1);
          if (exp_load.size() == 0) begin
            chk("load_unexpected_qsize", exp_load.size(), 1);
          end else begin
            e = exp_load.pop_front();
            chk("load_address", bus.load_address, e.l);
            chk("load_row", bus.load_row, e.r);
            chk("load_data_set", bus.load_data_set, {31'd0, e.s});
            cur_pend = 1'b1;
            prev_cmd = e;
          end
        end
        prev_pend = cur_pend;
        if (bus.store) begin
          n_store++;
          chk("store_needs_valid", bus.fwd_valid, 1'b1);
          if (exp_store.size() == 0) begin
            chk("store_unexpected_qsize", exp_store.size(), 1);
          end else begin
            e = exp_store.pop_front();
            chk("store_address", bus.store_address, e.l);
            chk("store_row", bus.store_row, e.r);
          end
        end
        code = bus.reset_counter ? 1 : bus.done ? 2 : bus.err ? 3 : 0;
        if (code != 0) begin
          if (exp_ctrl.size() == 0) chk("ctrl_unexpected", code, 0);
          else                      chk("ctrl_event", code, exp_ctrl.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    int i;
    bit f;
    bit b;
    reset         = 1'b1;
    bus.fwd_start = 1'b0;
    bus.bwd_start = 1'b0;
    bus.cfg_rows  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Forward and backward passes with free-flowing handshakes.
    start_pass(1'b1, 1'b0, 2, 1000, 1'b1);
    drain("fwd");
    start_pass(1'b0, 1'b1, 2, 1000, 1'b1);
    drain("bwd");

    // Backpressure mid-layer during the backward pass.
    base = n_load;
    start_pass(1'b0, 1'b1, 2, 1000, 1'b1);
    i = 0;
    while (i < 200 && n_load < base + 2) begin
      @(negedge clk); #1;
      i++;
    end
    chk("bp_loads_before_stall", n_load - base, 2);
    @(posedge clk);
    man       = 1'b1;
    man_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_no_load", bus.load, 1'b0);
      if (exp_load.size() != 0)
        chk("bp_hold_cmd", {bus.load_address, bus.load_row},
            {exp_load[0].l, exp_load[0].r});
    end
    @(posedge clk);
    man       = 1'b0;
    man_ready = 1'b1;
    drain("bp");

    // Rejected configurations.
    start_pass(1'b1, 1'b0, 0, 1000, 1'b1);
    drain("bad0");
    start_pass(1'b1, 1'b0, MAXR + 1, 1000, 1'b1);
    drain("bad6");

    // Reset after the third store, then a fresh pass with a colliding bwd_start.
    base = n_store;
    start_pass(1'b1, 1'b0, 2, 3, 1'b0);
    i = 0;
    while (i < 200 && n_store < base + 3) begin
      @(negedge clk); #1;
      i++;
    end
    chk("abort_stores_before_reset", n_store - base, 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_queues_left", exp_ctrl.size() + exp_store.size() + exp_load.size(), 0);
    repeat (3) @(negedge clk);
    start_pass(1'b1, 1'b1, 2, 1000, 1'b1);
    drain("restart");

    // Randomized passes with random handshakes.
    vmode = 1;
    rmode = 1;
    for (int n = 0; n < 10; n++) begin
      f = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (!f && !b) b = 1'b1;
      start_pass(f, b, int'($urandom_range(0, MAXR + 1)), 1000, 1'b1);
      drain("rand");
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
